ldpc_dec_wb_ctrl: RTL and testbench

//  Wishbone-slave sequencer for the user-area LDPC decoder core. Firmware loads an N-bit codeword,

---
 rtl/ldpc_dec_wb_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_ldpc_dec_wb_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_dec_wb_ctrl.sv
// Wishbone-slave sequencer for the LDPC decoder core: codeword/limit registers,
// launch/abort/watchdog FSM, result capture and a GPIO status signature.
module ldpc_dec_wb_ctrl #(
  parameter int          N         = 64,
  parameter int          ITER_W    = 8,
  parameter int          TMO_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              dec_start_o,
  output logic              dec_abort_o,
  output logic [N-1:0]      dec_cw_o,
  output logic [ITER_W-1:0] dec_maxit_o,
  input  logic              dec_done_i,
  input  logic              dec_pass_i,
  input  logic [ITER_W-1:0] dec_iter_i,
  input  logic [N-1:0]      dec_res_i,
  output logic [15:0]       io_status_o,
  output logic [15:0]       io_oeb_o,
  output logic              irq_o
);

  localparam int NW = N / 32;
  localparam logic [4:0] NW5 = 5'(N / 32);

  typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;

  state_t state, state_next;

  logic              access, wr, rd;
  logic [7:0]        off;
  logic [3:0]        word_idx;
  logic              word_ok;
  logic              ctrl_wr, start_wr, abort_wr, w1c, cw_wr;
  logic              busy;
  logic              launch, done_evt, tmo_evt, abort_evt;
  logic              done_f, pass_f, tmo_f, irq_en;
  logic [ITER_W-1:0] iter_q, maxit_q;
  logic [TMO_W-1:0]  timer_q, timer_inc, tmo_lim_q;
  logic [N-1:0]      cw_q, res_q;
  logic [31:0]       rdata;
  logic              unused_adr;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (sel[b]) r[8*b +: 8] = dat[8*b +: 8];
    return r;
  endfunction

  // The ack register gates access so back-to-back strobes see an idle ack cycle.
  assign access   = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]) & ~wbs_ack_o;
  assign wr       = access & wbs_we_i;
  assign rd       = access & ~wbs_we_i;
  assign off      = wbs_adr_i[7:0];
  assign word_idx = off[5:2];
  assign word_ok  = {1'b0, word_idx} < NW5;
  assign unused_adr = &{1'b0, wbs_adr_i[1:0]};

  assign ctrl_wr  = wr & (off == 8'h00) & wbs_sel_i[0];
  assign start_wr = ctrl_wr & wbs_dat_i[0];
  assign abort_wr = ctrl_wr & wbs_dat_i[1];
  assign w1c      = wr & (off == 8'h04) & wbs_sel_i[0] & wbs_dat_i[2];
  assign cw_wr    = wr & (off[7:6] == 2'b01) & word_ok & ~busy;

  assign busy      = (state != IDLE);
  assign timer_inc = timer_q + TMO_W'(1);

  assign dec_cw_o    = cw_q;
  assign dec_maxit_o = maxit_q;
  assign io_status_o = {12'hAB6, tmo_f, done_f, pass_f, busy};
  assign io_oeb_o    = 16'h0000;
  assign irq_o       = done_f & irq_en;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_next;
  end

  // Within RUN an abort write beats a completion, and a completion beats the watchdog.
  always_comb begin
    state_next = state;
    launch     = 1'b0;
    done_evt   = 1'b0;
    tmo_evt    = 1'b0;
    abort_evt  = 1'b0;
    case (state)
      IDLE:   if (start_wr) state_next = LAUNCH;
      LAUNCH: begin
        launch     = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        if (abort_wr) begin
          abort_evt  = 1'b1;
          state_next = IDLE;
        end else if (dec_done_i) begin
          done_evt   = 1'b1;
          state_next = IDLE;
        end else if (timer_inc == tmo_lim_q) begin
          tmo_evt    = 1'b1;
          abort_evt  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rdata = 32'h0;
    case (off)
      8'h00: rdata[2] = irq_en;
      8'h04: begin
        rdata[16 +: ITER_W] = iter_q;
        rdata[3:0]          = {tmo_f, done_f, pass_f, busy};
      end
      8'h08: rdata[ITER_W-1:0] = maxit_q;
      8'h0C: rdata[TMO_W-1:0]  = tmo_lim_q;
      default: begin
        for (int i = 0; i < NW; i++) begin
          if (word_idx == i[3:0] && off[7:6] == 2'b01) rdata = cw_q[32*i +: 32];
          if (word_idx == i[3:0] && off[7:6] == 2'b10) rdata = res_q[32*i +: 32];
        end
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= 32'h0;
      dec_start_o <= 1'b0;
      dec_abort_o <= 1'b0;
      done_f      <= 1'b0;
      pass_f      <= 1'b0;
      tmo_f       <= 1'b0;
      irq_en      <= 1'b0;
      iter_q      <= '0;
      res_q       <= '0;
      cw_q        <= '0;
      maxit_q     <= ITER_W'(10);
      tmo_lim_q   <= '1;
      timer_q     <= '0;
    end else begin
      wbs_ack_o   <= access;
      wbs_dat_o   <= rd ? rdata : 32'h0;
      dec_start_o <= launch;
      dec_abort_o <= abort_evt;

      if (launch)                timer_q <= '0;
      else if (state == RUN)     timer_q <= timer_inc;

      // A launch clears the sticky flags even if a W1C lands at the same time.
      if (launch) begin
        done_f <= 1'b0;
        pass_f <= 1'b0;
        tmo_f  <= 1'b0;
      end else if (done_evt) begin
        done_f <= 1'b1;
        pass_f <= dec_pass_i;
        iter_q <= dec_iter_i;
        res_q  <= dec_res_i;
      end else if (tmo_evt) begin
        done_f <= 1'b1;
        pass_f <= 1'b0;
        tmo_f  <= 1'b1;
      end else if (w1c) begin
        done_f <= 1'b0;
        pass_f <= 1'b0;
        tmo_f  <= 1'b0;
      end

      if (ctrl_wr) irq_en <= wbs_dat_i[2];
      if (wr && off == 8'h08)
        maxit_q <= ITER_W'(merge(32'(maxit_q), wbs_dat_i, wbs_sel_i));
      if (wr && off == 8'h0C)
        tmo_lim_q <= TMO_W'(merge(32'(tmo_lim_q), wbs_dat_i, wbs_sel_i));
      for (int i = 0; i < NW; i++)
        if (cw_wr && word_idx == i[3:0])
          cw_q[32*i +: 32] <= merge(cw_q[32*i +: 32], wbs_dat_i, wbs_sel_i);
    end
  end

endmodule

// File: tb/tb_ldpc_dec_wb_ctrl.sv
// Directed self-checking bench for ldpc_dec_wb_ctrl: register access, decode runs,
// watchdog, abort, event collisions, interrupt and mid-run reset.
module tb_ldpc_dec_wb_ctrl;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        dec_start_o, dec_abort_o;
  logic [63:0] dec_cw_o;
  logic [7:0]  dec_maxit_o;
  logic        dec_done_i, dec_pass_i;
  logic [7:0]  dec_iter_i;
  logic [63:0] dec_res_i;
  logic [15:0] io_status_o, io_oeb_o;
  logic        irq_o;

  int tests = 0;
  int fails = 0;
  int startCnt = 0;
  int abortCnt = 0;

  localparam logic [63:0] CW = 64'h0123_4567_89AB_CDEF;

  ldpc_dec_wb_ctrl dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .dec_start_o(dec_start_o), .dec_abort_o(dec_abort_o),
    .dec_cw_o(dec_cw_o), .dec_maxit_o(dec_maxit_o),
    .dec_done_i(dec_done_i), .dec_pass_i(dec_pass_i),
    .dec_iter_i(dec_iter_i), .dec_res_i(dec_res_i),
    .io_status_o(io_status_o), .io_oeb_o(io_oeb_o), .irq_o(irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  always @(negedge wb_clk_i) begin
    if (dec_start_o) startCnt++;
    if (dec_abort_o) abortCnt++;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge wb_clk_i);
      #1;
    end
  endtask

  // One Wishbone access; optionally pulses dec_done_i in the cycle the access is accepted.
  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [31:0] data,
                               input logic [3:0] sel, input logic expectAck, input logic withDone,
                               output logic [31:0] rdata);
    int ackCycles;
    ackCycles = 0;
    @(posedge wb_clk_i);
    #1;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = addr; wbs_dat_i = data; wbs_sel_i = sel;
    if (withDone) dec_done_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge wb_clk_i);
      #1;
      dec_done_i = 1'b0;
      if (wbs_ack_o) begin
        ackCycles = k;
        break;
      end
    end
    rdata = wbs_dat_o;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    checkOutput($sformatf("ack_latency@%h", addr), 64'(ackCycles), expectAck ? 64'd1 : 64'd0);
  endtask

  task automatic wbWrite(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] dummy;
    applyStimulus(addr, 1'b1, data, 4'hF, 1'b1, 1'b0, dummy);
  endtask

  task automatic wbRead(input logic [31:0] addr, output logic [31:0] data);
    applyStimulus(addr, 1'b0, 32'h0, 4'hF, 1'b1, 1'b0, data);
  endtask

  task automatic waitStart(output int lat);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge wb_clk_i);
      #1;
      if (dec_start_o) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic pulseDone(input logic pass, input logic [7:0] iter, input logic [63:0] res);
    dec_done_i = 1'b1; dec_pass_i = pass; dec_iter_i = iter; dec_res_i = res;
    cycles(1);
    dec_done_i = 1'b0; dec_pass_i = 1'b0;
  endtask

  initial begin
    logic [31:0] rdata;
    int lat, s0, a0;

    wb_rst_i = 1'b1;
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
    dec_done_i = 1'b0; dec_pass_i = 1'b0; dec_iter_i = 8'h0; dec_res_i = 64'h0;
    cycles(3);
    wb_rst_i = 1'b0;
    cycles(1);

    checkOutput("rst_status", 64'(io_status_o), 64'hAB60);
    checkOutput("rst_ack", 64'(wbs_ack_o), 64'd0);
    checkOutput("rst_start", 64'(dec_start_o), 64'd0);
    checkOutput("rst_abort", 64'(dec_abort_o), 64'd0);
    checkOutput("rst_cw", dec_cw_o, 64'd0);
    checkOutput("rst_irq", 64'(irq_o), 64'd0);
    checkOutput("rst_oeb", 64'(io_oeb_o), 64'd0);
    checkOutput("rst_maxit_port", 64'(dec_maxit_o), 64'd10);

    wbRead(32'h3000_0008, rdata);
    checkOutput("rst_maxit_reg", 64'(rdata), 64'd10);
    wbRead(32'h3000_000C, rdata);
    checkOutput("rst_tmolim_reg", 64'(rdata), 64'h0000_FFFF);

    // Address miss, unmapped offset, and per-byte write enables.
    applyStimulus(32'h4000_0008, 1'b0, 32'h0, 4'hF, 1'b0, 1'b0, rdata);
    wbWrite(32'h3000_0010, 32'hFFFF_FFFF);
    wbRead(32'h3000_0010, rdata);
    checkOutput("unmapped_read", 64'(rdata), 64'd0);
    applyStimulus(32'h3000_0008, 1'b1, 32'h0000_1107, 4'b0010, 1'b1, 1'b0, rdata);
    checkOutput("maxit_sel_skip", 64'(dec_maxit_o), 64'd10);
    applyStimulus(32'h3000_0008, 1'b1, 32'h0000_0C0C, 4'b0001, 1'b1, 1'b0, rdata);
    checkOutput("maxit_sel_byte0", 64'(dec_maxit_o), 64'h0C);

    wbWrite(32'h3000_0040, CW[31:0]);
    wbWrite(32'h3000_0044, CW[63:32]);
    checkOutput("cw_port", dec_cw_o, CW);

    // Normal run: done after 20 cycles with pass, iter 3.
    s0 = startCnt;
    wbWrite(32'h3000_0000, 32'h1);
    checkOutput("start_not_in_ack_cycle", 64'(dec_start_o), 64'd0);
    waitStart(lat);
    checkOutput("start_latency", 64'(lat), 64'd1);
    checkOutput("busy_status", 64'(io_status_o), 64'hAB61);
    wbWrite(32'h3000_0000, 32'h1);
    wbWrite(32'h3000_0040, 32'h0);
    checkOutput("cw_locked_busy", dec_cw_o, CW);
    cycles(16);
    pulseDone(1'b1, 8'd3, CW);
    checkOutput("pass_io_status", 64'(io_status_o), 64'hAB66);
    wbRead(32'h3000_0004, rdata);
    checkOutput("pass_status_reg", 64'(rdata), 64'h0003_0006);
    wbRead(32'h3000_0080, rdata);
    checkOutput("res_word0", 64'(rdata), 64'(CW[31:0]));
    wbRead(32'h3000_0084, rdata);
    checkOutput("res_word1", 64'(rdata), 64'(CW[63:32]));
    checkOutput("single_start_pulse", 64'(startCnt - s0), 64'd1);
    checkOutput("irq_disabled", 64'(irq_o), 64'd0);

    // Watchdog: no done, abort 50 cycles after the start pulse.
    wbWrite(32'h3000_000C, 32'd50);
    wbWrite(32'h3000_0000, 32'h1);
    waitStart(lat);
    a0 = abortCnt;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge wb_clk_i);
      #1;
      if (dec_abort_o) begin
        lat = k;
        break;
      end
    end
    checkOutput("tmo_abort_cycle", 64'(lat), 64'd50);
    checkOutput("tmo_io_status", 64'(io_status_o), 64'hAB6C);
    wbRead(32'h3000_0004, rdata);
    checkOutput("tmo_status_bits", 64'(rdata[3:0]), 64'hC);
    checkOutput("tmo_abort_once", 64'(abortCnt - a0), 64'd1);

    // Firmware abort during RUN, then a stray done outside RUN.
    wbWrite(32'h3000_000C, 32'h0000_FFFF);
    wbWrite(32'h3000_0000, 32'h1);
    waitStart(lat);
    cycles(3);
    wbWrite(32'h3000_0000, 32'h2);
    checkOutput("abort_pulse", 64'(dec_abort_o), 64'd1);
    checkOutput("abort_io_status", 64'(io_status_o), 64'hAB60);
    pulseDone(1'b1, 8'd7, 64'hFFFF_FFFF_FFFF_FFFF);
    checkOutput("idle_done_ignored", 64'(io_status_o), 64'hAB60);
    wbRead(32'h3000_0080, rdata);
    checkOutput("idle_done_res", 64'(rdata), 64'(CW[31:0]));

    // Abort write and done in the same cycle: abort wins, result dropped.
    wbWrite(32'h3000_0000, 32'h1);
    waitStart(lat);
    cycles(2);
    dec_pass_i = 1'b1; dec_iter_i = 8'd9; dec_res_i = 64'hDEAD_BEEF_DEAD_BEEF;
    applyStimulus(32'h3000_0000, 1'b1, 32'h2, 4'hF, 1'b1, 1'b1, rdata);
    dec_pass_i = 1'b0;
    checkOutput("abort_beats_done", 64'(io_status_o), 64'hAB60);
    wbRead(32'h3000_0080, rdata);
    checkOutput("abort_res_kept", 64'(rdata), 64'(CW[31:0]));

    // Done and watchdog on the same cycle: done wins.
    wbWrite(32'h3000_000C, 32'd30);
    wbWrite(32'h3000_0000, 32'h1);
    waitStart(lat);
    a0 = abortCnt;
    cycles(29);
    pulseDone(1'b1, 8'd5, CW);
    checkOutput("done_beats_tmo_abort", 64'(dec_abort_o), 64'd0);
    checkOutput("done_beats_tmo_io", 64'(io_status_o), 64'hAB66);
    cycles(2);
    checkOutput("done_beats_tmo_cnt", 64'(abortCnt - a0), 64'd0);
    wbRead(32'h3000_0004, rdata);
    checkOutput("done_beats_tmo_status", 64'(rdata), 64'h0005_0006);
    wbWrite(32'h3000_0004, 32'h4);
    checkOutput("w1c_io_status", 64'(io_status_o), 64'hAB60);

    // START+ABORT in one IDLE write with IRQ_EN; level interrupt until W1C.
    wbWrite(32'h3000_000C, 32'h0000_FFFF);
    s0 = startCnt;
    a0 = abortCnt;
    wbWrite(32'h3000_0000, 32'h7);
    waitStart(lat);
    checkOutput("start_abort_start", 64'(lat), 64'd1);
    checkOutput("start_abort_no_abort", 64'(abortCnt - a0), 64'd0);
    checkOutput("irq_before_done", 64'(irq_o), 64'd0);
    cycles(4);
    pulseDone(1'b0, 8'd2, CW);
    checkOutput("fail_io_status", 64'(io_status_o), 64'hAB64);
    checkOutput("irq_set", 64'(irq_o), 64'd1);
    cycles(5);
    checkOutput("irq_held", 64'(irq_o), 64'd1);
    wbRead(32'h3000_0000, rdata);
    checkOutput("ctrl_readback", 64'(rdata), 64'h4);
    wbWrite(32'h3000_0004, 32'h4);
    checkOutput("irq_cleared", 64'(irq_o), 64'd0);

    // Reset in the middle of a run.
    wbWrite(32'h3000_000C, 32'd100);
    wbWrite(32'h3000_0000, 32'h5);
    waitStart(lat);
    cycles(3);
    a0 = abortCnt;
    wb_rst_i = 1'b1;
    cycles(2);
    wb_rst_i = 1'b0;
    cycles(1);
    checkOutput("midrst_io_status", 64'(io_status_o), 64'hAB60);
    checkOutput("midrst_cw", dec_cw_o, 64'd0);
    checkOutput("midrst_maxit", 64'(dec_maxit_o), 64'd10);
    checkOutput("midrst_irq", 64'(irq_o), 64'd0);
    checkOutput("midrst_no_abort", 64'(abortCnt - a0), 64'd0);
    wbRead(32'h3000_000C, rdata);
    checkOutput("midrst_tmolim", 64'(rdata), 64'h0000_FFFF);
    wbRead(32'h3000_0000, rdata);
    checkOutput("midrst_ctrl", 64'(rdata), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
